// File: rtl/sd_cmd_sequencer.sv
// SD CMD-line sequencer: gated SD clock, 48-bit command frame with CRC7,
// optional 48-bit response capture with timeout and CRC/end-bit checking.
module sd_cmd_sequencer #(
    parameter int unsigned CLK_DIV      = 63,
    parameter int unsigned RESP_TIMEOUT = 64,
    parameter int unsigned TRAIL_CLKS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_en,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        crc_err,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        sd_clk_o,
    output logic        sd_cmd_o,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_i
);

    localparam int WW = $clog2(RESP_TIMEOUT + 1);
    localparam int TW = $clog2(TRAIL_CLKS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TX, S_WAIT, S_RX, S_TRAIL, S_DONE
    } state_e;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    state_e        state_q, state_d;
    logic [7:0]    div_q;
    logic          sclk_q;
    logic [47:0]   tx_q;
    logic [46:0]   rx_q;
    logic [5:0]    bit_q;
    logic [WW-1:0] wait_q;
    logic [TW-1:0] trail_q;
    logic          resp_en_q;
    logic          timeout_q;
    logic          crc_err_q;
    logic [5:0]    resp_index_q;
    logic [31:0]   resp_arg_q;

    logic          run;
    logic          div_hit;
    logic          rise_tick;
    logic          fall_tick;
    logic          accept;
    logic [47:0]   rx_next;
    logic [39:0]   frame_hdr;
    logic          wait_last;

    assign run       = state_q inside {S_TX, S_WAIT, S_RX, S_TRAIL};
    assign div_hit   = div_q == 8'(CLK_DIV);
    assign rise_tick = run && div_hit && !sclk_q;
    assign fall_tick = run && div_hit && sclk_q;
    assign accept    = (state_q == S_IDLE) && cmd_start;
    assign rx_next   = {rx_q, sd_cmd_i};
    assign frame_hdr = {2'b01, cmd_index, cmd_arg};
    assign wait_last = wait_q == WW'(RESP_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (cmd_start) state_d = S_TX;
            S_TX:    if (fall_tick && bit_q == 6'd47)
                         state_d = resp_en_q ? S_WAIT : S_TRAIL;
            S_WAIT:  if (rise_tick) begin
                         if (!sd_cmd_i)     state_d = S_RX;
                         else if (wait_last) state_d = S_TRAIL;
                     end
            S_RX:    if (rise_tick && bit_q == 6'd47) state_d = S_TRAIL;
            S_TRAIL: if (fall_tick && trail_q == TW'(TRAIL_CLKS - 1))
                         state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= '0;
            sclk_q       <= 1'b0;
            tx_q         <= '1;
            rx_q         <= '0;
            bit_q        <= '0;
            wait_q       <= '0;
            trail_q      <= '0;
            resp_en_q    <= 1'b0;
            timeout_q    <= 1'b0;
            crc_err_q    <= 1'b0;
            resp_index_q <= '0;
            resp_arg_q   <= '0;
        end else begin
            // divider idles low; DONE parks the clock for the next accept
            if (accept || !run) begin
                div_q  <= '0;
                sclk_q <= 1'b0;
            end else if (div_hit) begin
                div_q  <= '0;
                sclk_q <= ~sclk_q;
            end else begin
                div_q  <= div_q + 8'd1;
            end

            unique case (state_q)
                S_IDLE: if (cmd_start) begin
                    tx_q         <= {frame_hdr, crc7(frame_hdr), 1'b1};
                    resp_en_q    <= resp_en;
                    bit_q        <= '0;
                    wait_q       <= '0;
                    trail_q      <= '0;
                    timeout_q    <= 1'b0;
                    crc_err_q    <= 1'b0;
                    resp_index_q <= '0;
                    resp_arg_q   <= '0;
                end
                S_TX: if (fall_tick) begin
                    tx_q  <= {tx_q[46:0], 1'b1};
                    bit_q <= bit_q + 6'd1;
                end
                S_WAIT: if (rise_tick) begin
                    if (!sd_cmd_i) begin
                        rx_q  <= rx_next[46:0];
                        bit_q <= 6'd1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                        if (wait_last) timeout_q <= 1'b1;
                    end
                end
                S_RX: if (rise_tick) begin
                    rx_q  <= rx_next[46:0];
                    bit_q <= bit_q + 6'd1;
                    if (bit_q == 6'd47) begin
                        resp_index_q <= rx_next[45:40];
                        resp_arg_q   <= rx_next[39:8];
                        crc_err_q    <= (rx_next[7:1] != crc7(rx_next[47:8]))
                                        || !rx_next[0];
                    end
                end
                S_TRAIL: if (fall_tick) trail_q <= trail_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        sd_cmd_oe = 1'b0;
        sd_cmd_o  = 1'b1;
        unique case (state_q)
            S_TX: begin
                busy      = 1'b1;
                sd_cmd_oe = 1'b1;
                sd_cmd_o  = tx_q[47];
            end
            S_WAIT, S_RX, S_TRAIL: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign sd_clk_o   = sclk_q;
    assign timeout    = timeout_q;
    assign crc_err    = crc_err_q;
    assign resp_index = resp_index_q;
    assign resp_arg   = resp_arg_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench for sd_cmd_sequencer: captures the serial frame, models
// an SD card on the CMD line and checks status at each done pulse.
module tb_sd_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        resp_en = 1'b0;
    logic        sd_cmd_i = 1'b1;
    logic        busy, done, timeout, crc_err;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        sd_clk_o, sd_cmd_o, sd_cmd_oe;

    sd_cmd_sequencer #(
        .CLK_DIV(0), .RESP_TIMEOUT(64), .TRAIL_CLKS(8)
    ) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_en(resp_en),
        .busy(busy), .done(done), .timeout(timeout), .crc_err(crc_err),
        .resp_index(resp_index), .resp_arg(resp_arg),
        .sd_clk_o(sd_clk_o), .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe),
        .sd_cmd_i(sd_cmd_i)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_crc7(input logic [39:0] d);
        logic [6:0] r = '0;
        for (int i = 39; i >= 0; i--)
            r = {r[5:0], 1'b0} ^ ({7{r[6] ^ d[i]}} & 7'h09);
        return r;
    endfunction

    typedef struct {
        logic [47:0] frame;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        to;
        logic        ce;
        int          trail;
    } exp_t;

    exp_t sb[$];

    logic [47:0] reply = '1;
    bit          reply_en = 0;
    bit          tb_resp = 0;

    logic        sclk_p = 0, oe_p = 0, busy_p = 0, to_p = 0, done_p = 0;
    logic [47:0] cap = '0;
    int          oe_rises = 0, trail_falls = 0, wait_rises = 0;
    int          card_falls = 0, card_bits = 0, done_cnt = 0;
    bit          trail_on = 0, waiting = 0, card_on = 0;
    bit          rise, fall;
    exp_t        e;

    // Monitor and card model share one process so edge ordering is fixed.
    initial forever begin
        @(negedge clk);
        rise = sd_clk_o && !sclk_p;
        fall = !sd_clk_o && sclk_p;
        if (busy && !busy_p) begin
            cap = '0; oe_rises = 0; trail_falls = 0; wait_rises = 0;
            trail_on = 0; waiting = 0; card_on = 0;
            card_falls = 0; card_bits = 0;
        end
        if (rise && sd_cmd_oe) begin
            cap = {cap[46:0], sd_cmd_o};
            oe_rises++;
        end
        if (rise && waiting) wait_rises++;
        if (fall && trail_on) trail_falls++;
        if (oe_p && !sd_cmd_oe && busy) begin
            waiting    = tb_resp;
            trail_on   = !tb_resp;
            card_on    = reply_en;
            card_falls = 0;
        end else if (fall && card_on) begin
            card_falls++;
            if (card_falls >= 2 && card_bits < 48) begin
                sd_cmd_i = reply[47 - card_bits];
                card_bits++;
            end else begin
                sd_cmd_i = 1'b1;
            end
        end
        if (timeout && !to_p && waiting) begin
            chk("wait_rises", 64'(wait_rises), 64);
            waiting  = 0;
            trail_on = 1;
        end
        if (done) begin
            chk("done_width", done_p, 0);
            chk("busy_at_done", busy, 0);
            if (!done_p) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    chk("frame", cap, e.frame);
                    chk("oe_periods", 64'(oe_rises), 48);
                    chk("timeout", timeout, e.to);
                    chk("crc_err", crc_err, e.ce);
                    chk("resp_index", resp_index, e.idx);
                    chk("resp_arg", resp_arg, e.arg);
                    if (e.trail >= 0)
                        chk("trail_clks", 64'(trail_falls), 64'(e.trail));
                end
            end
        end
        sclk_p = sd_clk_o; oe_p = sd_cmd_oe; busy_p = busy;
        to_p = timeout; done_p = done;
    end

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic ren, input logic [47:0] frame,
                           input logic [5:0] eidx, input logic [31:0] earg,
                           input logic eto, input logic ece, input int trail,
                           input logic [47:0] rep, input bit rep_en,
                           input bit poke);
        int start;
        exp_t x;
        x.frame = frame; x.idx = eidx; x.arg = earg;
        x.to = eto; x.ce = ece; x.trail = trail;
        sb.push_back(x);
        reply = rep; reply_en = rep_en; tb_resp = ren;
        start = done_cnt;
        @(negedge clk);
        cmd_index = idx; cmd_arg = arg; resp_en = ren; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_index = ~idx; cmd_arg = ~arg; resp_en = ~ren;
        if (poke) begin
            repeat (10) @(negedge clk);
            cmd_start = 1'b1;
            @(negedge clk);
            cmd_start = 1'b0;
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done_cnt > start) break;
        end
        repeat (4) @(negedge clk);
        chk("done_count", 64'(done_cnt - start), 1);
        if (done_cnt == start) sb.delete();
    endtask

    initial begin
        logic [31:0] ra;
        logic [39:0] hdr;
        int          dc;
        repeat (3) @(negedge clk);
        chk("rst_sd_clk", sd_clk_o, 0);
        chk("rst_sd_cmd_o", sd_cmd_o, 1);
        chk("rst_sd_cmd_oe", sd_cmd_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_crc_err", crc_err, 0);
        chk("rst_resp", {resp_index, resp_arg}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_cmd(6'd0, 32'h0, 1'b0, 48'h400000000095, 6'h0, 32'h0,
                0, 0, 8, '1, 0, 0);
        run_cmd(6'd8, 32'h1AA, 1'b1, 48'h48000001AA87, 6'h08, 32'h1AA,
                0, 0, -1, 48'h08000001AA13, 1, 1);
        run_cmd(6'd55, 32'h0, 1'b1, 48'h770000000065, 6'h0, 32'h0,
                1, 0, 8, '1, 0, 0);
        run_cmd(6'd8, 32'h1AA, 1'b1, 48'h48000001AA87, 6'h08, 32'h1AA,
                0, 1, -1, 48'h08000001AA15, 1, 0);
        run_cmd(6'd8, 32'h1AA, 1'b1, 48'h48000001AA87, 6'h08, 32'h1AA,
                0, 1, -1, 48'h08000001AA12, 1, 0);

        ra  = $urandom;
        hdr = {2'b01, 6'd17, ra};
        run_cmd(6'd17, ra, 1'b0, {hdr, ref_crc7(hdr), 1'b1}, 6'h0, 32'h0,
                0, 0, 8, '1, 0, 0);

        // abort a transaction at bit 20
        tb_resp = 0; reply_en = 0;
        dc = done_cnt;
        @(negedge clk);
        cmd_index = 6'd17; cmd_arg = 32'hDEADBEEF; resp_en = 1'b1;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (oe_rises >= 20) break;
            @(negedge clk);
        end
        chk("abort_reached", 64'(oe_rises), 20);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_oe", sd_cmd_oe, 0);
        chk("abort_sd_clk", sd_clk_o, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cmd_o", sd_cmd_o, 1);
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - dc), 0);

        run_cmd(6'd0, 32'h0, 1'b0, 48'h400000000095, 6'h0, 32'h0,
                0, 0, 8, '1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
- Hardware sequencer for the SD card CMD line in native 1-bit SD bus mode. It replaces software bit-banging of the sd_clk/sd_cmd PIOs.
- It generates the gated SD clock and serialises a 48-bit command frame with CRC7. It then optionally waits for and captures a 48-bit response (R1/R3/R6/R7 format) and reports status.
- It sits between a Nios-visible control/status interface and the SD_CLK/SD_CMD pads. The tri-state buffer is outside the block.

Parameters:
- CLK_DIV, 63: sd_clk half-period is (CLK_DIV+1) clk cycles (50 MHz / 128 ≈ 390 kHz identification rate). Legal range 0..255.
- RESP_TIMEOUT, 64: maximum number of sd_clk rising edges to wait for a response start bit (NCR limit).
- TRAIL_CLKS, 8: sd_clk cycles issued after a transaction ends (NCC/NRC).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- cmd_start  in  1  single-cycle request; accepted only when busy=0
- cmd_index  in  6  command index, sampled on accept
- cmd_arg  in  32  command argument, sampled on accept
- resp_en  in  1  1 = expect a 48-bit response; sampled on accept
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse at end of transaction
- timeout  out  1  status: no response start bit within RESP_TIMEOUT
- crc_err  out  1  status: response CRC7 mismatch or end bit = 0
- resp_index  out  6  captured response bits [45:40]
- resp_arg  out  32  captured response bits [39:8]
- sd_clk_o  out  1  SD clock to pad
- sd_cmd_o  out  1  CMD output data
- sd_cmd_oe  out  1  CMD output enable (1 = drive)
- sd_cmd_i  in  1  CMD input from pad, already synchronised externally

Behaviour:
- Reset values: sd_clk_o=0, sd_cmd_o=1, sd_cmd_oe=0, busy=0, done=0, timeout=0, crc_err=0, resp_index=0, resp_arg=0. State=IDLE, divider=0.
- Reset asserted mid-operation: next edge returns to IDLE with all outputs at their reset values. There is no partial status and no done pulse.
- Clock divider:
  - Runs only when state≠IDLE; it is cleared on accept.
  - When the counter reaches CLK_DIV, sd_clk_o toggles and the counter clears.
  - rise_tick / fall_tick are internal one-cycle strobes coincident with the 0→1 / 1→0 toggle.
  - sd_clk_o is low in IDLE.
- Timing convention: the block changes CMD on fall_tick and samples sd_cmd_i on rise_tick.
- Accept: in IDLE with cmd_start=1.
  - Next cycle: busy=1, timeout=0, crc_err=0.
  - Frame latched: {0, 1, cmd_index, cmd_arg, crc7, 1}, where crc7 covers the first 40 bits.
  - sd_cmd_oe=1, sd_cmd_o=0 (start bit) → TX.
  - cmd_start while busy=1 is ignored.
- CRC7: polynomial x^7+x^3+1, register initialised to 0, MSB-first. It is computed serially or in parallel; the result must be identical.
- TX: bit 47 is driven from accept. Each fall_tick advances one bit. After the fall_tick that would follow bit 0:
  - sd_cmd_oe=0, sd_cmd_o=1.
  - If resp_en=1 go to WAIT, else go to TRAIL.
- WAIT: on each rise_tick:
  - If sd_cmd_i=0, this is the start bit. Shift it in and go to RX.
  - Otherwise increment the wait count. When the count reaches RESP_TIMEOUT, set timeout=1 and go to TRAIL.
- RX: shifts 47 further bits on rise_ticks (48 total). Then:
  - resp_index = bits[45:40], resp_arg = bits[39:8].
  - crc_err=1 if received bits[7:1] ≠ CRC7 of received bits[47:8], or if bit[0]=0.
  - Go to TRAIL.
- TRAIL: TRAIL_CLKS complete sd_clk periods with CMD released, counted on fall_ticks. Then go to DONE.
- DONE: done=1 for one cycle, busy=0, divider stops with sd_clk_o=0 → IDLE.
- Status retention: timeout, crc_err, resp_index and resp_arg hold until the next accept or reset.
- Bit period: 2*(CLK_DIV+1) clk cycles.
- Total TX duration: 48 bit periods from accept to release.

Test Plan:
- CMD0, arg 0x00000000, resp_en=0, CLK_DIV=0.
  - Required: serial CMD = 0x400000000095 MSB-first.
  - Required: sd_cmd_oe high for exactly 48 sd_clk periods, then 8 trailing clocks.
  - Required: done pulses once; timeout=0, crc_err=0.
- CMD8, arg 0x000001AA, resp_en=1; card model replies 0x08000001AA13 after 2 sd_clk periods.
  - Required: frame 0x48000001AA87.
  - Required: resp_index=0x08, resp_arg=0x000001AA, crc_err=0, timeout=0.
- CMD55, arg 0, resp_en=1; card model never drives CMD low.
  - Required: frame 0x770000000065.
  - Required: timeout=1 after exactly 64 rise_ticks; then 8 trailing clocks; then done.
- Same as CMD8, but the model returns 0x08000001AA15.
  - Required: crc_err=1; resp_arg still 0x000001AA.
- Same as CMD8, but the model returns 0x08000001AA12 (end bit 0).
  - Required: crc_err=1.
- Reset mid-TX: assert reset for 1 cycle at bit 20.
  - Required next cycle: sd_cmd_oe=0, sd_clk_o=0, busy=0, no done pulse.
  - Required: a following cmd_start is accepted normally.
  - Also check: cmd_start pulsed while busy has no effect on the frame.
